// File: rtl/composite_video_decoder.sv
// -----------------------------------------------------------------------------
// composite_video_decoder
//
// Purpose:
//   Receive end of a 2-bit composite video link (0=SYNC, 1=BLACK, 2=GRAY,
//   3=WHITE). Horizontal and vertical sync are told apart by the length of
//   each run of SYNC samples. From the sync events the decoder rebuilds the
//   active pixel coordinates and the pixel colour, and it reports whether the
//   incoming frame structure is stable ("locked").
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   pix_en       in   1  sample strobe; video_in is only looked at when high
//   video_in     in   2  composite level
//   hpos         out  9  active x (0..H_DISPLAY-1), holds outside active area
//   vpos         out  9  active y (0..V_DISPLAY-1), holds outside active area
//   pixel        out  2  video_in-1 inside the active area, 0 elsewhere
//   pixel_valid  out  1  locked and the latest sample was inside the active area
//   line_start   out  1  one-cycle pulse on each accepted hsync end
//   frame_start  out  1  one-cycle pulse on each vsync end
//   locked       out  1  previous frame carried exactly the expected line count
//   sync_err     out  1  one-cycle pulse on an illegal sync run or counter overflow
//
// Every output is registered and reflects the sample taken on the previous
// pix_en cycle. Level outputs hold between samples; pulses last one clock.
// -----------------------------------------------------------------------------
module composite_video_decoder #(
    parameter int H_DISPLAY = 256,
    parameter int H_BACK    = 60,
    parameter int V_DISPLAY = 240,
    parameter int V_TOP     = 18,
    parameter int V_BOTTOM  = 14,
    parameter int HSYNC_MIN = 16,
    parameter int HSYNC_MAX = 40,
    parameter int VSYNC_MIN = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [1:0] video_in,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic [1:0] pixel,
    output logic       pixel_valid,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    // Run-length thresholds at the width of the run counter.
    localparam logic [11:0] RUN_H_MIN = 12'(HSYNC_MIN);
    localparam logic [11:0] RUN_H_MAX = 12'(HSYNC_MAX);
    localparam logic [11:0] RUN_V_MIN = 12'(VSYNC_MIN);
    localparam logic [11:0] RUN_SAT   = 12'hFFF;

    // Active window bounds in raw counter space.
    localparam logic [8:0] H_LO    = 9'(H_BACK);
    localparam logic [8:0] H_HI    = 9'(H_BACK + H_DISPLAY);
    localparam logic [8:0] V_LO    = 9'(V_TOP);
    localparam logic [8:0] V_HI    = 9'(V_TOP + V_DISPLAY);

    // Line count a well-formed frame shows at vsync start, and the point past
    // which a missing vsync is declared.
    localparam logic [8:0] V_FRAME = 9'(V_TOP + V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] V_LIMIT = 9'(V_TOP + V_DISPLAY + V_BOTTOM + 8);

    localparam logic [8:0] H_SAT     = 9'd511;
    localparam logic [8:0] H_PRE_SAT = 9'd510;

    typedef enum logic {
        HUNT  = 1'b0,   // waiting for a vsync end, hsyncs do not count lines
        TRACK = 1'b1    // synchronised, counting lines
    } state_t;

    state_t      state;
    logic [11:0] run_cnt;   // consecutive SYNC samples seen so far
    logic [8:0]  hcnt;      // index of the latest non-sync sample since hsync end
    logic [8:0]  vcnt;      // hsync ends accepted since vsync end

    // Classification of the current sample.
    logic       is_sync;
    logic       run_end;
    logic       hsync_end;
    logic       vsync_end;
    logic       bad_run;
    logic       vsync_start;
    logic       h_ovf;
    logic       v_ovf;
    logic       err;
    logic       active;
    logic [8:0] h_next;
    logic [8:0] v_next;

    always_comb begin
        // NOTE: every signal gets a value on every path through this block, so
        // nothing here can be inferred as a latch.
        is_sync     = 1'b0;
        run_end     = 1'b0;
        hsync_end   = 1'b0;
        vsync_end   = 1'b0;
        bad_run     = 1'b0;
        vsync_start = 1'b0;
        h_ovf       = 1'b0;
        v_ovf       = 1'b0;
        err         = 1'b0;
        active      = 1'b0;
        h_next      = hcnt;
        v_next      = vcnt;

        is_sync = (video_in == 2'd0);

        // The run length is judged on the first non-sync sample after it.
        run_end   = !is_sync && (run_cnt != 12'd0);
        hsync_end = run_end && (run_cnt >= RUN_H_MIN) && (run_cnt <= RUN_H_MAX);
        vsync_end = run_end && (run_cnt >= RUN_V_MIN);
        bad_run   = run_end && !hsync_end && !vsync_end;

        // This sample is the one that makes the run long enough to be a vsync.
        vsync_start = is_sync && (run_cnt == RUN_V_MIN - 12'd1);

        // Horizontal position of this sample. The first sample after a run is
        // position 0; sync samples leave the position untouched.
        if (run_end) begin
            h_next = 9'd0;
        end else if (!is_sync && (hcnt != H_SAT)) begin
            h_next = hcnt + 9'd1;
        end
        h_ovf = !is_sync && !run_end && (hcnt == H_PRE_SAT);

        // Line index of this sample; hsyncs only count while tracking.
        if (vsync_end) begin
            v_next = 9'd0;
        end else if (hsync_end && (state == TRACK)) begin
            v_next = vcnt + 9'd1;
        end
        v_ovf = hsync_end && (state == TRACK) && (vcnt >= V_LIMIT);

        err = bad_run || h_ovf || v_ovf;

        active = (state == TRACK) && !is_sync
              && (h_next >= H_LO) && (h_next < H_HI)
              && (v_next >= V_LO) && (v_next < V_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state and outputs are assigned with <= so every register
            // samples the values from before this edge, regardless of order.
            state       <= HUNT;
            run_cnt     <= 12'd0;
            hcnt        <= 9'd0;
            vcnt        <= 9'd0;
            hpos        <= 9'd0;
            vpos        <= 9'd0;
            pixel       <= 2'd0;
            pixel_valid <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            // Pulses drop on every clock and are only raised by a sample.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;

            if (pix_en) begin
                if (!is_sync) begin
                    run_cnt <= 12'd0;
                end else if (run_cnt != RUN_SAT) begin
                    run_cnt <= run_cnt + 12'd1;
                end

                hcnt <= h_next;
                vcnt <= v_next;

                // A line-count overflow is an error, not an accepted hsync.
                line_start  <= hsync_end && (state == TRACK) && !v_ovf;
                frame_start <= vsync_end;
                sync_err    <= err;

                if (err) begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end else if (vsync_end) begin
                    state <= TRACK;
                end else if (vsync_start && (state == TRACK)) begin
                    // The line count of the frame just finished decides lock.
                    locked <= (vcnt == V_FRAME);
                end

                if (active) begin
                    hpos  <= h_next - H_LO;
                    vpos  <= v_next - V_LO;
                    pixel <= video_in - 2'd1;
                end else begin
                    pixel <= 2'd0;
                end

                // Lock is unaffected by any active sample (lock only changes
                // during sync or on an error), so the current value applies.
                pixel_valid <= active && locked && !err;
            end
        end
    end

endmodule
